// File: rtl/usb2_pkg.sv
// Shared USB 2.0 definitions: PID codes, scheduler state encoding and field widths.
package usb2_pkg;

  localparam int LEN_W   = 10;
  localparam int EPN_W   = 4;
  localparam int EP0_IDX = 0;
  localparam int TIMER_W = 8;

  // Token and handshake PIDs as they appear in the low nibble of the PID byte
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMMIT_REQ,
    ST_ARM_REQ,
    ST_DONE
  } ep_state_t;

endpackage

// File: rtl/usb2_ep_hs.sv
// One request/ack channel: tracks an outstanding request, detects the ack
// rising edge and aborts after TIMEOUT request cycles.
module usb2_ep_hs
  import usb2_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic phy_clk,
  input  logic reset_n,
  input  logic start,
  input  logic ack,
  output logic active,
  output logic hit,
  output logic expire
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

  logic               ack_prev;
  logic               ack_rise;
  logic [TIMER_W-1:0] timer;

  // A real ack edge wins over a timeout landing in the same cycle
  assign ack_rise = ack & ~ack_prev;
  assign hit      = active & (ack_rise | (timer == LAST));
  assign expire   = active & ~ack_rise & (timer == LAST);

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_prev <= 1'b0;
      active   <= 1'b0;
      timer    <= '0;
    end else begin
      ack_prev <= ack;
      if (start) begin
        active <= 1'b1;
        timer  <= '0;
      end else if (hit) begin
        active <= 1'b0;
      end else if (active) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb2_ep_sched.sv
// Endpoint scheduler between the USB 2.0 protocol layer and NUM_EP endpoints.
// Optional per-endpoint DATA0/DATA1 tracking is enabled with USB2_EP_TOGGLE_EN.
module usb2_ep_sched
  import usb2_pkg::*;
#(
  parameter int NUM_EP  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    phy_clk,
  input  logic                    reset_n,
  input  logic                    tok_valid,
  input  logic [EPN_W-1:0]        tok_ep,
  input  logic                    prot_commit,
  input  logic                    prot_arm,
  output logic                    prot_commit_ack,
  output logic                    prot_arm_ack,
  output logic                    prot_ready,
  output logic                    prot_hasdata,
  output logic [LEN_W-1:0]        prot_len,
  output logic [EPN_W-1:0]        sel_ep,
  input  logic [NUM_EP-1:0]       ep_ready,
  input  logic [NUM_EP-1:0]       ep_hasdata,
  input  logic [NUM_EP*LEN_W-1:0] ep_len,
  output logic [NUM_EP-1:0]       ep_commit,
  input  logic [NUM_EP-1:0]       ep_commit_ack,
  output logic [NUM_EP-1:0]       ep_arm,
  input  logic [NUM_EP-1:0]       ep_arm_ack,
  output logic                    err_timeout
`ifdef USB2_EP_TOGGLE_EN
  ,
  input  logic                    tok_setup,
  output logic [NUM_EP-1:0]       data_toggle
`endif
);

  ep_state_t         state, state_next;
  logic [EPN_W-1:0]  sel_next;
  logic              pend_arm, pend_next;
  logic [NUM_EP-1:0] commit_next, arm_next;
  logic              cack_next, aack_next, err_next;
  logic              c_start, a_start;
  logic              c_active, c_hit, c_expire;
  logic              a_active, a_hit, a_expire;
  logic              sel_valid;
  logic [NUM_EP-1:0] sel_onehot;
  logic              sel_commit_ack, sel_arm_ack;

  // Endpoint numbers at or above NUM_EP match no slot, so everything reads 0
  always_comb begin
    sel_valid      = 1'b0;
    sel_onehot     = '0;
    prot_ready     = 1'b0;
    prot_hasdata   = 1'b0;
    prot_len       = '0;
    sel_commit_ack = 1'b0;
    sel_arm_ack    = 1'b0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (sel_ep == EPN_W'(i)) begin
        sel_valid      = 1'b1;
        sel_onehot[i]  = 1'b1;
        prot_ready     = ep_ready[i];
        prot_hasdata   = ep_hasdata[i];
        prot_len       = ep_len[i*LEN_W +: LEN_W];
        sel_commit_ack = ep_commit_ack[i];
        sel_arm_ack    = ep_arm_ack[i];
      end
    end
  end

  usb2_ep_hs #(.TIMEOUT(TIMEOUT)) u_commit_hs (
    .phy_clk (phy_clk),
    .reset_n (reset_n),
    .start   (c_start),
    .ack     (sel_commit_ack),
    .active  (c_active),
    .hit     (c_hit),
    .expire  (c_expire)
  );

  usb2_ep_hs #(.TIMEOUT(TIMEOUT)) u_arm_hs (
    .phy_clk (phy_clk),
    .reset_n (reset_n),
    .start   (a_start),
    .ack     (sel_arm_ack),
    .active  (a_active),
    .hit     (a_hit),
    .expire  (a_expire)
  );

  always_comb begin
    state_next  = state;
    sel_next    = sel_ep;
    pend_next   = pend_arm;
    commit_next = ep_commit;
    arm_next    = ep_arm;
    cack_next   = 1'b0;
    aack_next   = 1'b0;
    err_next    = 1'b0;
    c_start     = 1'b0;
    a_start     = 1'b0;
    // Arms arriving while busy are deferred; commits cannot be, so they are flagged
    if (state != ST_IDLE) begin
      if (prot_arm)    pend_next = 1'b1;
      if (prot_commit) err_next  = 1'b1;
    end
    case (state)
      ST_IDLE: begin
        if (tok_valid) sel_next = tok_ep;
        if (prot_commit) begin
          if (prot_arm) pend_next = 1'b1;
          if (sel_valid) begin
            c_start     = 1'b1;
            commit_next = sel_onehot;
            state_next  = ST_COMMIT_REQ;
          end else begin
            cack_next  = 1'b1;
            err_next   = 1'b1;
            state_next = ST_DONE;
          end
        end else if (prot_arm || pend_arm) begin
          pend_next = 1'b0;
          if (sel_valid) begin
            a_start    = 1'b1;
            arm_next   = sel_onehot;
            state_next = ST_ARM_REQ;
          end else begin
            aack_next  = 1'b1;
            err_next   = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_COMMIT_REQ: begin
        if (c_active && c_hit) begin
          commit_next = '0;
          cack_next   = 1'b1;
          if (c_expire) err_next = 1'b1;
          state_next  = ST_DONE;
        end
      end
      ST_ARM_REQ: begin
        if (a_active && a_hit) begin
          arm_next   = '0;
          aack_next  = 1'b1;
          if (a_expire) err_next = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      sel_ep          <= '0;
      pend_arm        <= 1'b0;
      ep_commit       <= '0;
      ep_arm          <= '0;
      prot_commit_ack <= 1'b0;
      prot_arm_ack    <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      state           <= state_next;
      sel_ep          <= sel_next;
      pend_arm        <= pend_next;
      ep_commit       <= commit_next;
      ep_arm          <= arm_next;
      prot_commit_ack <= cack_next;
      prot_arm_ack    <= aack_next;
      err_timeout     <= err_next;
    end
  end

`ifdef USB2_EP_TOGGLE_EN
  // SETUP always starts the control data stage on DATA1
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      data_toggle <= '0;
    end else begin
      if ((c_hit && !c_expire) || (a_hit && !a_expire))
        data_toggle <= data_toggle ^ sel_onehot;
      if (state == ST_IDLE && tok_valid && tok_setup && tok_ep == EPN_W'(EP0_IDX))
        data_toggle[EP0_IDX] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_usb2_ep_sched.sv
// Directed self-checking bench for usb2_ep_sched (NUM_EP=4, TIMEOUT=8).
module tb_usb2_ep_sched;

  localparam int NUM_EP  = 4;
  localparam int TIMEOUT = 8;

  logic                 phy_clk;
  logic                 reset_n;
  logic                 tok_valid;
  logic [3:0]           tok_ep;
  logic                 prot_commit;
  logic                 prot_arm;
  logic                 prot_commit_ack;
  logic                 prot_arm_ack;
  logic                 prot_ready;
  logic                 prot_hasdata;
  logic [9:0]           prot_len;
  logic [3:0]           sel_ep;
  logic [NUM_EP-1:0]    ep_ready;
  logic [NUM_EP-1:0]    ep_hasdata;
  logic [NUM_EP*10-1:0] ep_len;
  logic [NUM_EP-1:0]    ep_commit;
  logic [NUM_EP-1:0]    ep_commit_ack;
  logic [NUM_EP-1:0]    ep_arm;
  logic [NUM_EP-1:0]    ep_arm_ack;
  logic                 err_timeout;
`ifdef USB2_EP_TOGGLE_EN
  logic                 tok_setup;
  logic [NUM_EP-1:0]    data_toggle;
`endif

  int checks   = 0;
  int failures = 0;

  int c_high, a_high, c_any, a_any;
  int cack_n, aack_n, err_n, overlap_n;
  int cack_first, aack_first, err_first;

  usb2_ep_sched #(.NUM_EP(NUM_EP), .TIMEOUT(TIMEOUT)) dut (
    .phy_clk         (phy_clk),
    .reset_n         (reset_n),
    .tok_valid       (tok_valid),
    .tok_ep          (tok_ep),
    .prot_commit     (prot_commit),
    .prot_arm        (prot_arm),
    .prot_commit_ack (prot_commit_ack),
    .prot_arm_ack    (prot_arm_ack),
    .prot_ready      (prot_ready),
    .prot_hasdata    (prot_hasdata),
    .prot_len        (prot_len),
    .sel_ep          (sel_ep),
    .ep_ready        (ep_ready),
    .ep_hasdata      (ep_hasdata),
    .ep_len          (ep_len),
    .ep_commit       (ep_commit),
    .ep_commit_ack   (ep_commit_ack),
    .ep_arm          (ep_arm),
    .ep_arm_ack      (ep_arm_ack),
    .err_timeout     (err_timeout)
`ifdef USB2_EP_TOGGLE_EN
    ,
    .tok_setup       (tok_setup),
    .data_toggle     (data_toggle)
`endif
  );

  initial phy_clk = 1'b0;
  always #5 phy_clk = ~phy_clk;

  task automatic tick();
    @(posedge phy_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_token(input logic [3:0] ep, input logic setup);
    tok_valid = 1'b1;
    tok_ep    = ep;
`ifdef USB2_EP_TOGGLE_EN
    tok_setup = setup;
`else
    if (setup) $display("[TB] setup flag ignored in this build");
`endif
    tick();
    tok_valid = 1'b0;
`ifdef USB2_EP_TOGGLE_EN
    tok_setup = 1'b0;
`endif
  endtask

  task automatic apply_stimulus(input logic c, input logic a);
    prot_commit = c;
    prot_arm    = a;
    tick();
    prot_commit = 1'b0;
    prot_arm    = 1'b0;
  endtask

  // Observes n cycles after a strobe while acting as endpoint ep: each channel
  // raises its ack after seeing the request for dly cycles and holds it 4 cycles.
  // At cycle inj_at a stray token (EP3) and commit are injected.
  task automatic run_ep(input int ep, input int dly, input int n, input int inj_at);
    int c_cyc = 0;
    int a_cyc = 0;
    int c_hold = 0;
    int a_hold = 0;
    logic [NUM_EP-1:0] oh;
    oh = NUM_EP'(1) << ep;
    c_high = 0; a_high = 0; c_any = 0; a_any = 0;
    cack_n = 0; aack_n = 0; err_n = 0; overlap_n = 0;
    cack_first = -1; aack_first = -1; err_first = -1;
    for (int k = 0; k < n; k++) begin
      if (ep_commit == oh) c_high++;
      if (ep_arm == oh) a_high++;
      if (ep_commit != '0) c_any++;
      if (ep_arm != '0) a_any++;
      if ($countones({ep_commit, ep_arm}) > 1) overlap_n++;
      if (prot_commit_ack) begin cack_n++; if (cack_first < 0) cack_first = k; end
      if (prot_arm_ack) begin aack_n++; if (aack_first < 0) aack_first = k; end
      if (err_timeout) begin err_n++; if (err_first < 0) err_first = k; end
      if (ep_commit[ep]) begin c_cyc++; if (c_cyc == dly) c_hold = 4; end
      if (ep_arm[ep]) begin a_cyc++; if (a_cyc == dly) a_hold = 4; end
      ep_commit_ack[ep] = (c_hold > 0);
      ep_arm_ack[ep]    = (a_hold > 0);
      if (c_hold > 0) c_hold--;
      if (a_hold > 0) a_hold--;
      if (k == inj_at) begin
        tok_valid   = 1'b1;
        tok_ep      = 4'd3;
        prot_commit = 1'b1;
      end else begin
        tok_valid   = 1'b0;
        prot_commit = 1'b0;
      end
      tick();
    end
    tok_valid     = 1'b0;
    prot_commit   = 1'b0;
    ep_commit_ack = '0;
    ep_arm_ack    = '0;
  endtask

  initial begin
    reset_n       = 1'b0;
    tok_valid     = 1'b0;
    tok_ep        = 4'd0;
    prot_commit   = 1'b0;
    prot_arm      = 1'b0;
    ep_ready      = '0;
    ep_hasdata    = '0;
    ep_len        = '0;
    ep_commit_ack = '0;
    ep_arm_ack    = '0;
`ifdef USB2_EP_TOGGLE_EN
    tok_setup     = 1'b0;
`endif
    tick();
    tick();
    check_output("rst_ep_commit", 32'(ep_commit), 32'd0);
    check_output("rst_ep_arm", 32'(ep_arm), 32'd0);
    check_output("rst_sel_ep", 32'(sel_ep), 32'd0);
    check_output("rst_acks", {30'd0, prot_commit_ack, prot_arm_ack}, 32'd0);
    check_output("rst_err", 32'(err_timeout), 32'd0);
    reset_n = 1'b1;
    tick();

`ifdef USB2_EP_TOGGLE_EN
    $display("[TB] toggle tracking");
    send_token(4'd0, 1'b1);
    check_output("tog_setup_ep0", 32'(data_toggle), 32'h1);
    send_token(4'd1, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    run_ep(1, 2, 6, -1);
    check_output("tog_ep1_first", 32'(data_toggle), 32'h3);
    apply_stimulus(1'b1, 1'b0);
    run_ep(1, 2, 6, -1);
    check_output("tog_ep1_second", 32'(data_toggle), 32'h1);
`endif

    $display("[TB] EP2 commit with status mux");
    ep_ready   = 4'b0100;
    ep_hasdata = 4'b1011;
    ep_len     = {10'd4, 10'd300, 10'd2, 10'd1};
    send_token(4'd2, 1'b0);
    check_output("t1_sel_ep", 32'(sel_ep), 32'd2);
    check_output("t1_ready", 32'(prot_ready), 32'd1);
    check_output("t1_hasdata", 32'(prot_hasdata), 32'd0);
    check_output("t1_len", 32'(prot_len), 32'd300);
    apply_stimulus(1'b1, 1'b0);
    run_ep(2, 4, 10, -1);
    check_output("t1_req_cycles", 32'(c_high), 32'd4);
    check_output("t1_cack_count", 32'(cack_n), 32'd1);
    check_output("t1_cack_cycle", 32'(cack_first), 32'd4);
    check_output("t1_err", 32'(err_n), 32'd0);
    check_output("t1_onehot", 32'(overlap_n), 32'd0);

    $display("[TB] busy token and commit during EP1 commit");
    send_token(4'd1, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    run_ep(1, 5, 12, 1);
    check_output("busy_req_cycles", 32'(c_high), 32'd5);
    check_output("busy_cack_cycle", 32'(cack_first), 32'd5);
    check_output("busy_err_cycle", 32'(err_first), 32'd2);
    check_output("busy_err_count", 32'(err_n), 32'd1);
    check_output("busy_sel_hold", 32'(sel_ep), 32'd1);

    $display("[TB] simultaneous commit and arm on EP0");
    send_token(4'd0, 1'b0);
    apply_stimulus(1'b1, 1'b1);
    run_ep(0, 3, 14, -1);
    check_output("t2_commit_cycles", 32'(c_high), 32'd3);
    check_output("t2_arm_cycles", 32'(a_high), 32'd3);
    check_output("t2_cack_cycle", 32'(cack_first), 32'd3);
    check_output("t2_aack_cycle", 32'(aack_first), 32'd8);
    check_output("t2_ack_counts", 32'(cack_n * 16 + aack_n), 32'h11);
    check_output("t2_err", 32'(err_n), 32'd0);
    check_output("t2_onehot", 32'(overlap_n), 32'd0);

    $display("[TB] EP1 timeout");
    send_token(4'd1, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    run_ep(1, 100, 12, -1);
    check_output("t3_req_cycles", 32'(c_high), 32'd8);
    check_output("t3_cack_cycle", 32'(cack_first), 32'd8);
    check_output("t3_err_cycle", 32'(err_first), 32'd8);
    check_output("t3_err_count", 32'(err_n), 32'd1);

    $display("[TB] invalid endpoint arm");
    ep_ready   = 4'b1111;
    ep_hasdata = 4'b1111;
    send_token(4'd7, 1'b0);
    check_output("t4_sel_ep", 32'(sel_ep), 32'd7);
    check_output("t4_status", {21'd0, prot_ready, prot_hasdata, prot_len}, 32'd0);
    apply_stimulus(1'b0, 1'b1);
    run_ep(0, 2, 4, -1);
    check_output("t4_no_req", 32'(c_any + a_any), 32'd0);
    check_output("t4_aack_cycle", 32'(aack_first), 32'd0);
    check_output("t4_err_cycle", 32'(err_first), 32'd0);
    check_output("t4_counts", 32'(aack_n * 16 + err_n), 32'h11);

    $display("[TB] reset during arm request");
    send_token(4'd2, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    tick();
    check_output("t5_arm_before", 32'(ep_arm), 32'h4);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("t5_arm_async", 32'(ep_arm), 32'd0);
    check_output("t5_sel_async", 32'(sel_ep), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    send_token(4'd3, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    run_ep(3, 2, 6, -1);
    check_output("t5_req_cycles", 32'(c_high), 32'd2);
    check_output("t5_cack_cycle", 32'(cack_first), 32'd2);
    check_output("t5_err", 32'(err_n), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
